// File: rtl/gray_burst_ctrl_if.sv
// Command/observation bundle between a burst master and the Gray-code position sequencer.
// Latency: wires only; no state in the interface.
// Backpressure: cmd_valid/cmd_ready handshake; the sequencer is the slave side.
interface gray_burst_ctrl_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_len;
  logic         cmd_dir;
  logic         cmd_clear;
  logic         pause;
  logic         abort;
  logic [N-1:0] gray;
  logic         step;
  logic         busy;
  logic         done;
  logic         err;

  // Command master: issues bursts and run controls, observes the position.
  modport master (
    output cmd_valid, cmd_len, cmd_dir, cmd_clear, pause, abort,
    input  cmd_ready, gray, step, busy, done, err
  );

  // Sequencer: accepts bursts and publishes the Gray-coded position.
  modport slave (
    input  cmd_valid, cmd_len, cmd_dir, cmd_clear, pause, abort,
    output cmd_ready, gray, step, busy, done, err
  );
endinterface

// File: rtl/gray_burst_ctrl.sv
// Burst sequencer: steps an N-bit position once per cycle and presents it Gray-coded.
// Latency: command accepted at edge k gives the first step at edge k+1; outputs are registered.
// Backpressure: cmd_ready only in IDLE; bursts are separated by a one-cycle DONE pulse.
module gray_burst_ctrl #(
  parameter int N       = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  gray_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] bin_q,   bin_d;
  logic [N-1:0] rem_q,   rem_d;
  logic         dir_q,   dir_d;
  logic         step_q,  step_d;
  logic         err_q,   err_d;

  // The step about to be taken would leave the range (only matters when saturating).
  logic at_limit;
  assign at_limit = dir_q ? (bin_q == '0) : (bin_q == '1);

  // Next-state and datapath updates; abort beats pause beats stepping.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    err_d   = err_q;
    step_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          dir_d   = bus.cmd_dir;
          rem_d   = bus.cmd_len;
          err_d   = 1'b0;
          if (bus.cmd_clear) bin_d = '0;
          state_d = (bus.cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (at_limit && !WRAP_EN) begin
          // Saturate: hold the position, flag it and drop the rest of the burst.
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          bin_d   = dir_q ? (bin_q - ONE) : (bin_q + ONE);
          step_d  = 1'b1;
          rem_d   = rem_q - ONE;
          if (rem_q == ONE) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.gray      = bin_q ^ (bin_q >> 1);
  assign bus.step      = step_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_gray_burst_ctrl.sv
// Bench for gray_burst_ctrl: one wrapping and one saturating instance share the same stimulus.
// Each instance is compared every cycle against a behavioural model of the burst rules.
module tb_gray_burst_ctrl;
  localparam int N    = 4;
  localparam int MAXV = (1 << N) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_burst_ctrl_if #(.N(N)) bus0 ();
  gray_burst_ctrl_if #(.N(N)) bus1 ();

  gray_burst_ctrl #(.N(N), .WRAP_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gray_burst_ctrl #(.N(N), .WRAP_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: position as an integer, steps left, phase of the burst.
  int m_pos[2];
  int m_rem[2];
  int m_ph[2];
  bit m_dir[2];
  bit m_err[2];
  bit m_step[2];
  bit m_wrap[2] = '{1'b1, 1'b0};

  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_rem[i] = 0; m_ph[i] = P_IDLE;
      m_dir[i] = 1'b0; m_err[i] = 1'b0; m_step[i] = 1'b0;
    end
  endtask

  // What one clock edge does to a burst, given the inputs presented before it.
  task automatic model_edge(input int i, input bit v, input int len, input bit d,
                            input bit c, input bit p, input bit a);
    int nxt;
    m_step[i] = 1'b0;
    case (m_ph[i])
      P_IDLE: if (v) begin
        m_dir[i] = d;
        m_rem[i] = len;
        m_err[i] = 1'b0;
        if (c) m_pos[i] = 0;
        m_ph[i] = (len == 0) ? P_DONE : P_RUN;
      end
      P_RUN: begin
        if (a) m_ph[i] = P_DONE;
        else if (p) m_ph[i] = P_PAUSE;
        else begin
          nxt = m_pos[i] + (m_dir[i] ? -1 : 1);
          if (!m_wrap[i] && (nxt < 0 || nxt > MAXV)) begin
            m_err[i] = 1'b1;
            m_ph[i]  = P_DONE;
          end else begin
            m_pos[i]  = (nxt + MAXV + 1) % (MAXV + 1);
            m_step[i] = 1'b1;
            m_rem[i]  = m_rem[i] - 1;
            if (m_rem[i] == 0) m_ph[i] = P_DONE;
          end
        end
      end
      P_PAUSE: begin
        if (a) m_ph[i] = P_DONE;
        else if (!p) m_ph[i] = P_RUN;
      end
      default: m_ph[i] = P_IDLE;
    endcase
  endtask

  task automatic check_dut(input int i);
    logic [N-1:0] g;
    logic s, b, dn, r, e;
    if (i == 0) begin
      g = bus0.gray; s = bus0.step; b = bus0.busy; dn = bus0.done; r = bus0.cmd_ready; e = bus0.err;
    end else begin
      g = bus1.gray; s = bus1.step; b = bus1.busy; dn = bus1.done; r = bus1.cmd_ready; e = bus1.err;
    end
    chk($sformatf("d%0d_gray", i), 32'(g), 32'(gray_of(m_pos[i])));
    chk($sformatf("d%0d_step", i), 32'(s), 32'(m_step[i]));
    chk($sformatf("d%0d_busy", i), 32'(b), 32'(m_ph[i] == P_RUN || m_ph[i] == P_PAUSE));
    chk($sformatf("d%0d_done", i), 32'(dn), 32'(m_ph[i] == P_DONE));
    chk($sformatf("d%0d_rdy", i), 32'(r), 32'(m_ph[i] == P_IDLE));
    chk($sformatf("d%0d_err", i), 32'(e), 32'(m_err[i]));
  endtask

  // Present inputs, advance the model and the DUTs by one edge, then compare.
  task automatic tick(input bit v, input int len, input bit d, input bit c,
                      input bit p, input bit a);
    bus0.cmd_valid = v; bus0.cmd_len = N'(len); bus0.cmd_dir = d;
    bus0.cmd_clear = c; bus0.pause = p; bus0.abort = a;
    bus1.cmd_valid = v; bus1.cmd_len = N'(len); bus1.cmd_dir = d;
    bus1.cmd_clear = c; bus1.pause = p; bus1.abort = a;
    model_edge(0, v, len, d, c, p, a);
    model_edge(1, v, len, d, c, p, a);
    @(posedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    if (bus0.step) q0.push_back(bus0.gray);
    if (bus1.step) q1.push_back(bus1.gray);
  endtask

  task automatic idle();
    tick(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Let both instances settle back to ready, within a fixed cycle budget.
  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (m_ph[0] == P_IDLE && m_ph[1] == P_IDLE) break;
      idle();
    end
    chk("drain_rdy", 32'(bus0.cmd_ready & bus1.cmd_ready), 32'd1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    chk("rst_async_gray", 32'(bus0.gray), 32'd0);
    chk("rst_async_rdy", 32'(bus0.cmd_ready), 32'd1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] e2[5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    logic [N-1:0] e3[3] = '{4'b1000, 4'b0000, 4'b0001};
    logic [N-1:0] e5[4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

    rst = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_len = '0; bus0.cmd_dir = 1'b0;
    bus0.cmd_clear = 1'b0; bus0.pause = 1'b0; bus0.abort = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_len = '0; bus1.cmd_dir = 1'b0;
    bus1.cmd_clear = 1'b0; bus1.pause = 1'b0; bus1.abort = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    chk("reset_gray", 32'(bus0.gray), 32'd0);
    chk("reset_rdy", 32'(bus0.cmd_ready), 32'd1);
    rst = 1'b0;

    // Reset in the middle of an 8-step up burst, after three steps.
    tick(1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle();
    chk("t1_pre_gray", 32'(bus0.gray), 32'b0010);
    mid_reset();
    chk("t1_no_done", 32'(bus0.done), 32'd0);

    // Basic up burst of five from a cleared position.
    q0.delete();
    tick(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) idle();
    chk("t2_done", 32'(bus0.done), 32'd1);
    idle();
    chk("t2_rdy", 32'(bus0.cmd_ready), 32'd1);
    chk("t2_nsteps", 32'(q0.size()), 32'd5);
    for (int k = 0; k < 5 && k < q0.size(); k++) chk($sformatf("t2_seq%0d", k), 32'(q0[k]), 32'(e2[k]));

    // Wrap from 14 going up; the saturating twin stops at 15 and flags err.
    tick(1'b1, 14, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t3_start", 32'(bus0.gray), 32'b1001);
    q0.delete();
    tick(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t3_nsteps", 32'(q0.size()), 32'd3);
    for (int k = 0; k < 3 && k < q0.size(); k++) chk($sformatf("t3_seq%0d", k), 32'(q0[k]), 32'(e3[k]));
    chk("t3_err_wrap", 32'(bus0.err), 32'd0);
    chk("t3_err_sat", 32'(bus1.err), 32'd1);

    // Saturate going down from 0; then a no-op command clears err.
    q1.delete();
    tick(1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t4_done", 32'(bus1.done), 32'd1);
    chk("t4_err", 32'(bus1.err), 32'd1);
    chk("t4_gray", 32'(bus1.gray), 32'd0);
    drain();
    chk("t4_nsteps", 32'(q1.size()), 32'd0);
    tick(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_err_clr", 32'(bus1.err), 32'd0);
    chk("t6_noop_done", 32'(bus1.done), 32'd1);
    chk("t6_noop_step", 32'(bus1.step), 32'd0);
    drain();

    // Pause for two cycles after the second step, then resume.
    q0.delete();
    tick(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_hold", 32'(bus0.gray), 32'b0011);
    idle();
    chk("t5_resume_nostep", 32'(bus0.step), 32'd0);
    drain();
    chk("t5_nsteps", 32'(q0.size()), 32'd4);
    for (int k = 0; k < 4 && k < q0.size(); k++) chk($sformatf("t5_seq%0d", k), 32'(q0[k]), 32'(e5[k]));

    // Abort while paused: done next cycle, position frozen.
    q0.delete();
    tick(1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_abort_done", 32'(bus0.done), 32'd1);
    chk("t6_abort_gray", 32'(bus0.gray), 32'b0001);
    drain();
    chk("t6_abort_nsteps", 32'(q0.size()), 32'd1);

    // Random traffic with occasional pauses, aborts and resets.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        tick(1'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
